// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: control and serial-output bundle of the pattern transmitter.
// Ports: Start/Pattern/Len/Repeat/Hold (master->slave), w/Valid/Busy/Done/CurState (slave->master).
interface seq_pattern_tx_if #(
   parameter int MAXLEN = 16,
   parameter int LENW   = 5
);
   logic              Start;
   logic [MAXLEN-1:0] Pattern;
   logic [LENW-1:0]   Len;
   logic [3:0]        Repeat;
   logic              Hold;
   logic              w;
   logic              Valid;
   logic              Busy;
   logic              Done;
   logic [3:0]        CurState;

   modport master (
      output Start, Pattern, Len, Repeat, Hold,
      input  w, Valid, Busy, Done, CurState
   );

   modport slave (
      input  Start, Pattern, Len, Repeat, Hold,
      output w, Valid, Busy, Done, CurState
   );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial MSB-first bit-pattern transmitter with repeats and idle gaps.
// Ports: Clock, Reset (sync, active-high), bus (seq_pattern_tx_if.slave).
module seq_pattern_tx #(
   parameter int MAXLEN = 16,
   parameter int GAP    = 2,
   parameter int LENW   = 5
) (
   input  logic Clock,
   input  logic Reset,
   seq_pattern_tx_if.slave bus
);
   localparam int IW = $clog2(MAXLEN);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_SHIFT = 4'd1,
      S_GAP   = 4'd2,
      S_DONE  = 4'd3
   } state_t;

   state_t            state, nxt_state;
   logic [MAXLEN-1:0] pat_q, nxt_pat;
   logic [LENW-1:0]   len_q, nxt_len;
   logic [IW-1:0]     idx_q, nxt_idx;
   logic [3:0]        rep_q, nxt_rep;
   logic [GW-1:0]     gap_q, nxt_gap;
   logic              w_q, valid_q, busy_q, done_q;

   logic          len_ok;
   logic [IW-1:0] reload;

   assign len_ok = (bus.Len != '0) && (bus.Len <= LENW'(MAXLEN));
   assign reload = IW'(len_q - 1'b1);

   always_comb begin
      nxt_state = state;
      nxt_pat   = pat_q;
      nxt_len   = len_q;
      nxt_idx   = idx_q;
      nxt_rep   = rep_q;
      nxt_gap   = gap_q;
      unique case (state)
         S_IDLE: begin
            if (bus.Start) begin
               nxt_pat = bus.Pattern;
               nxt_len = bus.Len;
               nxt_rep = bus.Repeat;
               if (len_ok) begin
                  nxt_state = S_SHIFT;
                  nxt_idx   = IW'(bus.Len - 1'b1);
               end else begin
                  nxt_state = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            if (!bus.Hold) begin
               if (idx_q != '0) begin
                  nxt_idx = idx_q - 1'b1;
               end else if (rep_q != 4'd0) begin
                  nxt_rep = rep_q - 4'd1;
                  if (GAP > 0) begin
                     nxt_state = S_GAP;
                     nxt_gap   = GW'(GAP - 1);
                  end else begin
                     // back-to-back repeat, no bubble
                     nxt_idx = reload;
                  end
               end else begin
                  nxt_state = S_DONE;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               nxt_idx   = reload;
               nxt_state = S_SHIFT;
            end else begin
               nxt_gap = gap_q - 1'b1;
            end
         end
         S_DONE: begin
            nxt_state = S_IDLE;
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next-state values so that
   // they line up with the state they describe.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= S_IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         w_q     <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= nxt_state;
         pat_q   <= nxt_pat;
         len_q   <= nxt_len;
         idx_q   <= nxt_idx;
         rep_q   <= nxt_rep;
         gap_q   <= nxt_gap;
         w_q     <= (nxt_state == S_SHIFT) && nxt_pat[nxt_idx];
         valid_q <= (nxt_state == S_SHIFT);
         busy_q  <= (nxt_state != S_IDLE);
         done_q  <= (nxt_state == S_DONE);
      end
   end

   assign bus.w        = w_q;
   assign bus.Valid    = valid_q & ~bus.Hold;
   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;
   assign bus.CurState = state;
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial bit-pattern transmitter. It loads a pattern of up to MAXLEN bits and shifts it out MSB-first, one bit per clock, on a single-bit line w. It can repeat the pattern with zero-filled gaps between repeats. It drives the serial w input of the team's sequence-detector FSMs, so benches and board demos can exercise them with programmed bit streams instead of manual switch toggling.

Parameters:
MAXLEN, 16, maximum pattern length in bits; legal range 2..32.
GAP, 2, number of idle cycles (w=0, Valid=0) inserted between repeats; 0 means back-to-back repeats.
LENW, 5, width of the Len port; must hold the value MAXLEN.

Ports:
Clock  input  1  system clock; all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request transmission; sampled only in IDLE.
Pattern  input  MAXLEN  bits to send; Pattern[Len-1] goes first, Pattern[0] last.
Len  input  LENW  number of bits per transmission, 1..MAXLEN.
Repeat  input  4  extra transmissions; total transmissions = Repeat+1.
Hold  input  1  stall; freezes the shift while high.
w  output  1  serial data bit.
Valid  output  1  w carries a pattern bit this cycle.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse when the job completes.
CurState  output  4  state encoding, for LED/debug.

Behaviour:
- Reset and Clock: reset is Reset, synchronous, active-high; the clock is Clock. Reset has priority over all other inputs.
- Reset values: state=IDLE, w=0, Valid=0, Busy=0, Done=0, CurState=0, all internal counters=0.
- States and CurState encodings: IDLE=0, SHIFT=1, GAP=2, DONE=3.
- IDLE:
  - Start=1 at a posedge captures Pattern, Len and Repeat into internal registers.
  - If the captured Len is legal (1..MAXLEN), go to SHIFT with bit index = Len-1 and repeat counter = Repeat.
  - If Len=0 or Len>MAXLEN, go directly to DONE; no bits are sent.
- Input stability: Pattern, Len and Repeat may change freely after capture; the block uses only the captured copies.
- SHIFT:
  - w = captured Pattern[bit index].
  - Valid = ~Hold.
  - At a posedge with Hold=1: no state change.
  - At a posedge with Hold=0 and bit index>0: decrement the bit index.
- SHIFT, end of pattern (bit index=0, Hold=0 at posedge):
  - Repeat counter>0 and GAP>0: decrement the counter, load the gap counter with GAP-1, go to GAP.
  - Repeat counter>0 and GAP=0: decrement the counter, reload bit index = Len-1, stay in SHIFT. There is no bubble between repeats.
  - Repeat counter=0: go to DONE.
- GAP:
  - w=0, Valid=0. Hold is ignored.
  - Gap counter=0 at a posedge: reload bit index = Len-1 and go to SHIFT.
  - Otherwise decrement the gap counter.
  - The gap lasts exactly GAP cycles.
- DONE: Done=1 and w=0 for exactly one cycle, then IDLE.
- Start outside IDLE is ignored; no queuing. Start held high continuously restarts a new job on the cycle after DONE.
- Latency:
  - Start sampled at posedge k → first bit valid in cycle k+1.
  - With no Hold, a job lasts (Repeat+1)*Len + Repeat*GAP cycles in SHIFT/GAP, then 1 cycle in DONE.
- Output timing: all outputs are decoded from registered state only; no combinational path from Start to w. Valid is the only output that depends combinationally on an input (Hold).
- Reset mid-operation: the next cycle is IDLE with all outputs 0. No Done pulse is produced and the captured data is discarded.
- Len=1: one bit per transmission; SHIFT lasts one cycle per repeat.
- Repeat=15: exactly 16 transmissions; the 4-bit counter must not wrap.

Test Plan:
- Pattern=...1101, Len=4, Repeat=0, GAP=2, Start pulse → w=1,1,0,1 with Valid=1 for 4 cycles; then Done=1 for one cycle with Busy=1; then Busy=0.
- Pattern=...1101, Len=4, Repeat=1, GAP=2 → w/Valid = 1101 (Valid=1), then 0,0 (Valid=0), then 1101 (Valid=1), then Done. Total 11 cycles from the first bit to the end of Done.
- Pattern=...1111, Len=4, Repeat=0, Hold=1 during the 2nd bit for 3 cycles → w stays 1 with Valid=0 during the hold; the sequence resumes with no bit lost or duplicated; Done at cycle 8.
- Len=0 with Start, then Len=20 (MAXLEN=16) with Start → each produces a Done pulse on the cycle after Start, with no Valid cycles.
- Reset asserted during the 3rd bit of a Len=8 job, and Start pulsed while Busy in a separate job → reset case: IDLE next cycle, all outputs 0, no Done. Busy case: Start ignored, exactly one Done.
- Repeat=15, GAP=0, Len=2, Pattern=10 → 32 consecutive Valid cycles alternating 1,0, then one Done pulse.
